wb_conbus_arb: RTL and testbench

//  Parametrised Wishbone interconnect: 2 masters (LM32 I/D) to NUM_SLAVES slaves. Top-nibble address decode.

---
 rtl/wb_conbus_arb.sv | 198 +++++++++++++++++++
 tb/tb_wb_conbus_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_conbus_arb.sv
// Wishbone interconnect from the two LM32 masters (I/D) to NUM_SLAVES slaves: top-bit address
// decode, round-robin or fixed-priority arbitration, unmapped-address error and a stall watchdog.
module wb_conbus_arb #(
  parameter int                             NUM_SLAVES  = 8,
  parameter int                             S_ADDR_W    = 4,
  parameter logic [NUM_SLAVES*S_ADDR_W-1:0] SLAVE_ADDRS = 32'h8765_4320,
  parameter bit                             ARB_RR      = 1'b1,
  parameter int                             TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                m0_adr_i,
  input  logic [31:0]                m0_dat_i,
  output logic [31:0]                m0_dat_o,
  input  logic [3:0]                 m0_sel_i,
  input  logic                       m0_we_i,
  input  logic                       m0_cyc_i,
  input  logic                       m0_stb_i,
  output logic                       m0_ack_o,
  output logic                       m0_err_o,
  input  logic [31:0]                m1_adr_i,
  input  logic [31:0]                m1_dat_i,
  output logic [31:0]                m1_dat_o,
  input  logic [3:0]                 m1_sel_i,
  input  logic                       m1_we_i,
  input  logic                       m1_cyc_i,
  input  logic                       m1_stb_i,
  output logic                       m1_ack_o,
  output logic                       m1_err_o,
  output logic [31:0]                s_adr_o,
  output logic [31:0]                s_dat_o,
  output logic [3:0]                 s_sel_o,
  output logic                       s_we_o,
  output logic [NUM_SLAVES-1:0]      s_cyc_o,
  output logic [NUM_SLAVES-1:0]      s_stb_o,
  input  logic [32*NUM_SLAVES-1:0]   s_dat_i,
  input  logic [NUM_SLAVES-1:0]      s_ack_i
);

  localparam int SW    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_gnt;
  logic            r_last;
  logic [WD_W-1:0] r_wd;
  logic            r_unm_err;

  logic                  w_busy;
  logic                  w_req0;
  logic                  w_req1;
  logic [31:0]           w_adr;
  logic [31:0]           w_wdat;
  logic [3:0]            w_sel;
  logic                  w_we;
  logic                  w_cyc;
  logic                  w_stb;
  logic [NUM_SLAVES-1:0] w_match;
  logic [SW-1:0]         w_idx;
  logic                  w_hit;
  logic                  w_ack;
  logic                  w_to;
  logic                  w_err;
  logic [31:0]           w_rdat;

  assign w_busy = (r_state == ST_BUSY);
  assign w_req0 = m0_cyc_i & m0_stb_i;
  assign w_req1 = m1_cyc_i & m1_stb_i;

  // Granted master's request view; all zero while no grant is held
  always_comb begin
    if (w_busy) begin
      if (r_gnt) begin
        w_adr  = m1_adr_i;
        w_wdat = m1_dat_i;
        w_sel  = m1_sel_i;
        w_we   = m1_we_i;
        w_cyc  = m1_cyc_i;
        w_stb  = m1_stb_i;
      end else begin
        w_adr  = m0_adr_i;
        w_wdat = m0_dat_i;
        w_sel  = m0_sel_i;
        w_we   = m0_we_i;
        w_cyc  = m0_cyc_i;
        w_stb  = m0_stb_i;
      end
    end else begin
      w_adr  = 32'h0000_0000;
      w_wdat = 32'h0000_0000;
      w_sel  = 4'h0;
      w_we   = 1'b0;
      w_cyc  = 1'b0;
      w_stb  = 1'b0;
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
    assign w_match[gi] = (w_adr[31 -: S_ADDR_W] == SLAVE_ADDRS[gi*S_ADDR_W +: S_ADDR_W]);
  end

  // Priority encode the decode hits; walking downwards lets the lowest index win duplicates
  always_comb begin
    w_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      w_idx = w_match[i] ? SW'(i) : w_idx;
    end
  end

  assign w_hit  = w_busy & (|w_match);
  assign w_ack  = w_hit & w_stb & s_ack_i[w_idx];
  assign w_rdat = w_hit ? s_dat_i[32*w_idx +: 32] : 32'h0000_0000;
  // A slave ack landing in the expiry cycle beats the watchdog
  assign w_to   = WD_EN & w_hit & w_stb & ~w_ack & (r_wd == WD_LAST);
  assign w_err  = w_busy & (w_to | (r_unm_err & ~w_ack));

  // Shared slave buses plus per-slave cyc/stb, suppressed in the watchdog expiry cycle
  always_comb begin
    s_adr_o = w_adr;
    s_dat_o = w_wdat;
    s_sel_o = w_sel;
    s_we_o  = w_we;
    s_cyc_o = '0;
    s_stb_o = '0;
    if (w_hit & ~w_to) begin
      s_cyc_o[w_idx] = w_cyc;
      s_stb_o[w_idx] = w_stb;
    end else begin
      s_cyc_o = '0;
      s_stb_o = '0;
    end
  end

  assign m0_ack_o = ~r_gnt & w_ack;
  assign m1_ack_o =  r_gnt & w_ack;
  assign m0_err_o = ~r_gnt & w_err;
  assign m1_err_o =  r_gnt & w_err;
  assign m0_dat_o = r_gnt ? 32'h0000_0000 : w_rdat;
  assign m1_dat_o = r_gnt ? w_rdat : 32'h0000_0000;

  // Arbitration FSM, unmapped-error pulse and watchdog counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 1'b0;
      r_last    <= 1'b1;
      r_wd      <= '0;
      r_unm_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wd      <= '0;
          r_unm_err <= 1'b0;
          if (w_req0 & w_req1) begin
            r_gnt   <= ARB_RR ? ~r_last : 1'b0;
            r_state <= ST_BUSY;
          end else if (w_req0) begin
            r_gnt   <= 1'b0;
            r_state <= ST_BUSY;
          end else if (w_req1) begin
            r_gnt   <= 1'b1;
            r_state <= ST_BUSY;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (!w_cyc) begin
            r_state   <= ST_IDLE;
            r_last    <= r_gnt;
            r_wd      <= '0;
            r_unm_err <= 1'b0;
          end else begin
            // Unmapped strobe: one err cycle, then re-armed if the master keeps strobing
            r_unm_err <= w_stb & ~w_hit & ~r_unm_err;
            if (!w_stb || !w_hit || w_ack || w_err) begin
              r_wd <= '0;
            end else begin
              r_wd <= r_wd + WD_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_conbus_arb.sv
// Self-checking bench for wb_conbus_arb: a round-robin instance (TIMEOUT=16) and a fixed-priority
// twin share all inputs; expected responses go through a scoreboard queue.
module tb_wb_conbus_arb;

  localparam int NS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [31:0]        m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]         m0_sel_i, m1_sel_i;
  logic               m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [32*NS-1:0]   s_dat_i;
  logic [NS-1:0]      s_ack_i;

  logic [31:0]        m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic               m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_we_o;
  logic [3:0]         s_sel_o;
  logic [NS-1:0]      s_cyc_o, s_stb_o;

  logic [31:0]        f_m0_dat_o, f_m1_dat_o, f_s_adr_o, f_s_dat_o;
  logic               f_m0_ack_o, f_m0_err_o, f_m1_ack_o, f_m1_err_o, f_s_we_o;
  logic [3:0]         f_s_sel_o;
  logic [NS-1:0]      f_s_cyc_o, f_s_stb_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  wb_conbus_arb #(.NUM_SLAVES(NS), .S_ADDR_W(4), .SLAVE_ADDRS(32'h8765_4320),
                  .ARB_RR(1'b1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  wb_conbus_arb #(.NUM_SLAVES(NS), .S_ADDR_W(4), .SLAVE_ADDRS(32'h8765_4320),
                  .ARB_RR(1'b0), .TIMEOUT(16)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(f_m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(f_m0_ack_o),
    .m0_err_o(f_m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(f_m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(f_m1_ack_o),
    .m1_err_o(f_m1_err_o),
    .s_adr_o(f_s_adr_o), .s_dat_o(f_s_dat_o), .s_sel_o(f_s_sel_o), .s_we_o(f_s_we_o),
    .s_cyc_o(f_s_cyc_o), .s_stb_o(f_s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  task automatic set_master(input int m, input logic req, input logic [31:0] adr);
    if (m == 0) begin
      m0_adr_i = adr; m0_dat_i = ~adr; m0_sel_i = 4'hF; m0_we_i = 1'b0;
      m0_cyc_i = req; m0_stb_i = req;
    end else begin
      m1_adr_i = adr; m1_dat_i = ~adr; m1_sel_i = 4'hF; m1_we_i = 1'b0;
      m1_cyc_i = req; m1_stb_i = req;
    end
  endtask

  // One single-beat transfer on the RR instance; k counts cycles from the request cycle (k=0).
  // ack_dly<0 means the slave never acks. Holds the strobe one cycle past the response.
  task automatic run_xfer(input int m, input logic [31:0] adr, input int ack_dly, input int limit,
      output int first_stb, output int n_stb, output int ack_at, output int err_at,
      output logic [31:0] rdat, output logic [31:0] adr_seen, output logic [NS-1:0] stb_seen,
      output logic [NS-1:0] stb_at_err, output logic other_resp, output logic extra_resp);
    logic done;
    first_stb = -1; n_stb = 0; ack_at = -1; err_at = -1; rdat = 32'h0; adr_seen = 32'h0;
    stb_seen = '0; stb_at_err = '0; other_resp = 1'b0; extra_resp = 1'b0; done = 1'b0;
    @(negedge clk);
    set_master(m, 1'b1, adr);
    for (int k = 0; k < limit && !done; k++) begin
      if (k > 0) @(negedge clk);
      s_ack_i = '0;
      #1;
      if (s_stb_o != '0) begin
        if (first_stb < 0) begin
          first_stb = k;
          adr_seen  = s_adr_o;
        end
        n_stb++;
        stb_seen |= s_stb_o;
        if (ack_dly >= 0 && k - first_stb == ack_dly) s_ack_i = s_stb_o;
      end
      #1;
      if ((m == 0) ? m0_ack_o : m1_ack_o) begin
        ack_at = k; rdat = (m == 0) ? m0_dat_o : m1_dat_o; done = 1'b1;
      end
      if ((m == 0) ? m0_err_o : m1_err_o) begin
        err_at = k; stb_at_err = s_stb_o; done = 1'b1;
      end
      if ((m == 0) ? (m1_ack_o | m1_err_o | (m1_dat_o != 32'h0))
                   : (m0_ack_o | m0_err_o | (m0_dat_o != 32'h0))) other_resp = 1'b1;
    end
    @(negedge clk);
    s_ack_i = '0;
    #2;
    if ((m == 0) ? (m0_ack_o | m0_err_o) : (m1_ack_o | m1_err_o)) extra_resp = 1'b1;
    @(negedge clk);
    set_master(m, 1'b0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    set_master(0, 1'b1, 32'h2000_0000);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ((s_cyc_o | s_stb_o) !== '0) begin
      n_errors++; $display("FAIL reset_slave: got cyc=%b stb=%b expected 0", s_cyc_o, s_stb_o);
    end
    n_checks++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_resp: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    end
    n_checks++;
    if ({f_s_stb_o, s_adr_o} !== {NS'(0), 32'h0}) begin
      n_errors++; $display("FAIL reset_bus: got stb_fp=%b adr=%h expected 0", f_s_stb_o, s_adr_o);
    end
    set_master(0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    int fs, ns, aa, ea; logic [31:0] rd, ad; logic [NS-1:0] sv, se; logic orr, er;
    exp_q.push_back(32'hCAFE_F00D);
    run_xfer(1, 32'h2000_0004, 2, 10, fs, ns, aa, ea, rd, ad, sv, se, orr, er);
    n_checks++;
    if (fs !== 1) begin n_errors++; $display("FAIL read_stb_latency: got %0d expected 1", fs); end
    n_checks++;
    if (sv !== 8'b0000_0010) begin n_errors++; $display("FAIL read_stb_vec: got %b expected 00000010", sv); end
    n_checks++;
    if (ad !== 32'h2000_0004) begin n_errors++; $display("FAIL read_adr: got %h expected 20000004", ad); end
    n_checks++;
    if (aa !== 3) begin n_errors++; $display("FAIL read_ack_time: got %0d expected 3", aa); end
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (rd !== e) begin n_errors++; $display("FAIL read_data: got %h expected %h", rd, e); end
    end
    n_checks++;
    if ({orr, er, (ea != -1)} !== 3'b000) begin
      n_errors++; $display("FAIL read_side_resp: got other=%b extra=%b err_at=%0d expected none", orr, er, ea);
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] e;
    for (int t = 0; t < 3; t++) begin
      exp_q.push_back({16'h0, 8'((t % 2 == 0) ? 8'b01 : 8'b10), 8'b01});
      @(negedge clk);
      set_master(0, 1'b1, 32'h0000_0010);
      set_master(1, 1'b1, 32'h2000_0020);
      @(negedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (s_stb_o !== e[15:8]) begin
        n_errors++; $display("FAIL arb_rr_%0d: got %b expected %b", t, s_stb_o, e[15:8]);
      end
      n_checks++;
      if (f_s_stb_o !== e[7:0]) begin
        n_errors++; $display("FAIL arb_fixed_%0d: got %b expected %b", t, f_s_stb_o, e[7:0]);
      end
      s_ack_i = s_stb_o | f_s_stb_o;
      #1;
      n_checks++;
      if ({m0_ack_o, m1_ack_o, f_m0_ack_o, f_m1_ack_o} !== {e[8], e[9], 2'b10}) begin
        n_errors++; $display("FAIL arb_ack_%0d: got %b expected %b", t,
          {m0_ack_o, m1_ack_o, f_m0_ack_o, f_m1_ack_o}, {e[8], e[9], 2'b10});
      end
      @(negedge clk);
      s_ack_i = '0;
      set_master(0, 1'b0, 32'h0);
      set_master(1, 1'b0, 32'h0);
    end
    @(negedge clk);
  endtask

  task automatic test_unmapped;
    int fs, ns, aa, ea; logic [31:0] rd, ad, e; logic [NS-1:0] sv, se; logic orr, er;
    exp_q.push_back(32'd2);
    run_xfer(0, 32'hF000_0000, 1, 8, fs, ns, aa, ea, rd, ad, sv, se, orr, er);
    e = exp_q.pop_front();
    n_checks++;
    if (ea !== int'(e)) begin n_errors++; $display("FAIL unmapped_err_time: got %0d expected %0d", ea, e); end
    n_checks++;
    if (sv !== '0) begin n_errors++; $display("FAIL unmapped_no_stb: got %b expected 0", sv); end
    n_checks++;
    if ({(aa != -1), er, orr} !== 3'b000) begin
      n_errors++; $display("FAIL unmapped_pulse: got ack_at=%0d extra=%b other=%b expected none", aa, er, orr);
    end
  endtask

  task automatic test_timeout;
    int fs, ns, aa, ea; logic [31:0] rd, ad, e; logic [NS-1:0] sv, se; logic orr, er;
    exp_q.push_back(32'd15);
    run_xfer(1, 32'h4000_0100, -1, 40, fs, ns, aa, ea, rd, ad, sv, se, orr, er);
    e = exp_q.pop_front();
    n_checks++;
    if (ea - fs !== int'(e) || fs !== 1) begin
      n_errors++; $display("FAIL timeout_err_time: got first=%0d err=%0d expected first=1 err=%0d", fs, ea, 1 + e);
    end
    n_checks++;
    if (ns !== 15) begin n_errors++; $display("FAIL timeout_stb_cycles: got %0d expected 15", ns); end
    n_checks++;
    if ({sv, se} !== {8'b0000_1000, 8'b0}) begin
      n_errors++; $display("FAIL timeout_stb: got seen=%b at_err=%b expected 00001000/0", sv, se);
    end
    n_checks++;
    if ({(aa != -1), er, orr} !== 3'b000) begin
      n_errors++; $display("FAIL timeout_pulse: got ack_at=%0d extra=%b other=%b expected none", aa, er, orr);
    end
    exp_q.push_back(32'h5A00_0003);
    run_xfer(1, 32'h4000_0104, 0, 10, fs, ns, aa, ea, rd, ad, sv, se, orr, er);
    e = exp_q.pop_front();
    n_checks++;
    if ({aa, ea} !== {32'd1, -32'sd1} || rd !== e) begin
      n_errors++; $display("FAIL timeout_recover: got ack_at=%0d err_at=%0d dat=%h expected 1/-1/%h", aa, ea, rd, e);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    set_master(0, 1'b1, 32'h0000_0040);
    @(negedge clk);
    set_master(1, 1'b1, 32'h2000_0000);
    #1;
    s_ack_i = s_stb_o;
    #1;
    n_checks++;
    if ({s_stb_o, m0_ack_o, m1_ack_o} !== {8'b01, 2'b10}) begin
      n_errors++; $display("FAIL b2b_first: got stb=%b ack=%b%b expected 00000001 10", s_stb_o, m0_ack_o, m1_ack_o);
    end
    @(negedge clk);
    s_ack_i = '0;
    m0_stb_i = 1'b0;
    #1;
    n_checks++;
    if ({s_cyc_o, s_stb_o} !== {8'b01, 8'b00}) begin
      n_errors++; $display("FAIL b2b_gap: got cyc=%b stb=%b expected 00000001/0", s_cyc_o, s_stb_o);
    end
    @(negedge clk);
    set_master(0, 1'b1, 32'h0000_0044);
    #1;
    n_checks++;
    if ({s_stb_o, s_adr_o} !== {8'b01, 32'h0000_0044}) begin
      n_errors++; $display("FAIL b2b_held: got stb=%b adr=%h expected 00000001/00000044", s_stb_o, s_adr_o);
    end
    s_ack_i = s_stb_o;
    #1;
    n_checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
      n_errors++; $display("FAIL b2b_second_ack: got %b expected 10", {m0_ack_o, m1_ack_o});
    end
    @(negedge clk);
    s_ack_i = '0;
    set_master(0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (s_stb_o !== 8'b10) begin n_errors++; $display("FAIL b2b_handover: got %b expected 00000010", s_stb_o); end
    set_master(1, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    set_master(0, 1'b1, 32'h3000_0000);
    @(negedge clk);
    #1;
    n_checks++;
    if (s_stb_o !== 8'b0000_0100) begin n_errors++; $display("FAIL abort_pre: got %b expected 00000100", s_stb_o); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ((s_stb_o | s_cyc_o) !== '0) begin n_errors++; $display("FAIL abort_stb: got %b expected 0", s_stb_o | s_cyc_o); end
    s_ack_i = 8'b0000_0100;
    #1;
    n_checks++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
      n_errors++; $display("FAIL abort_late_ack: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    end
    set_master(0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({m0_ack_o, m1_ack_o, s_stb_o} !== {2'b00, 8'b0}) begin
      n_errors++; $display("FAIL abort_after: got ack=%b%b stb=%b expected 0", m0_ack_o, m1_ack_o, s_stb_o);
    end
    s_ack_i = '0;
  endtask

  initial begin
    s_ack_i = '0;
    for (int i = 0; i < NS; i++) s_dat_i[32*i +: 32] = 32'h5A00_0000 | 32'(i);
    s_dat_i[32 +: 32] = 32'hCAFE_F00D;
    set_master(1, 1'b0, 32'h0);
    test_reset();
    test_read();
    test_arbitration();
    test_unmapped();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
